// File: rtl/dot_scan_controller_if.sv
// Dot-position ROM bus: the controller drives the address, and the ROM returns
// the dot centre and power flag one cycle later.
interface dot_scan_controller_if #(
   parameter int IDX_W = 6
);
   logic [IDX_W-1:0] rom_addr;
   logic [9:0]       rom_x;
   logic [9:0]       rom_y;
   logic             rom_power;

   modport master (output rom_addr, input rom_x, input rom_y, input rom_power);
   modport slave  (input rom_addr, output rom_x, output rom_y, output rom_power);
endinterface

// File: rtl/dot_scan_controller.sv
// Shared dot-eaten detector: once per frame it sweeps a single hit comparator over
// the dot ROM, and it keeps the alive bitmap, score, dots-left count and event pulses.
module dot_scan_controller #(
   parameter int NUM_DOTS  = 64,
   parameter int IDX_W     = 6,
   parameter int BALL_SIZE = 8,
   parameter int HIT_WIN   = 4,
   parameter int DOT_PTS   = 10,
   parameter int POWER_PTS = 50
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_start,
   input  logic                  level_restart,
   input  logic [9:0]            PacX,
   input  logic [9:0]            PacY,
   dot_scan_controller_if.master rom,
   input  logic [IDX_W-1:0]      qry_idx,
   output logic                  qry_alive,
   output logic [15:0]           score,
   output logic [IDX_W:0]        dots_left,
   output logic                  eat_pulse,
   output logic                  power_pulse,
   output logic                  level_clear,
   output logic                  scan_busy
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [IDX_W-1:0]   LAST_ADDR = IDX_W'(NUM_DOTS - 1);
   localparam logic [IDX_W:0]     DOTS_FULL = (IDX_W + 1)'(NUM_DOTS);
   localparam logic signed [11:0] BS        = 12'(BALL_SIZE);
   localparam logic signed [11:0] WIN       = 12'(HIT_WIN);

   state_t                state_q;
   logic [9:0]            px_q, py_q;
   logic [IDX_W:0]        cnt_q;
   logic [IDX_W-1:0]      rom_addr_q;
   logic [NUM_DOTS-1:0]   alive_q;
   logic                  pending_q;

   logic signed [11:0]    px_s, py_s, dx_s, dy_s;
   logic                  hit, cmp_valid, eat_now;
   logic [IDX_W-1:0]      cmp_idx;
   logic [16:0]           score_sum;
   logic [15:0]           score_next;

   function automatic logic in_win(input logic signed [11:0] d);
      return (d >= -WIN) && (d <= WIN);
   endfunction

   assign rom.rom_addr = rom_addr_q;
   assign qry_alive    = alive_q[qry_idx];
   assign level_clear  = (dots_left == '0);
   assign scan_busy    = (state_q != S_IDLE);

   // 12-bit signed corners so px-BALL_SIZE near 0 goes negative instead of wrapping
   assign px_s = $signed({2'b00, px_q});
   assign py_s = $signed({2'b00, py_q});
   assign dx_s = $signed({2'b00, rom.rom_x});
   assign dy_s = $signed({2'b00, rom.rom_y});

   // Compare stage trails the address by one cycle; cnt_q==k means ROM data for k-1
   assign cmp_valid = (state_q == S_SCAN) && (cnt_q != '0);
   assign cmp_idx   = cnt_q[IDX_W-1:0] - 1'b1;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no latch can be inferred.
      hit        = 1'b0;
      eat_now    = 1'b0;
      score_sum  = {1'b0, score} + (rom.rom_power ? 17'(POWER_PTS) : 17'(DOT_PTS));
      score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      // Four corners pair every x edge with every y edge, so the test factors per axis
      hit        = (in_win(px_s - BS - dx_s) | in_win(px_s + BS - dx_s)) &
                   (in_win(py_s - BS - dy_s) | in_win(py_s + BS - dy_s));
      eat_now    = cmp_valid && hit && alive_q[cmp_idx];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         px_q        <= '0;
         py_q        <= '0;
         cnt_q       <= '0;
         rom_addr_q  <= '0;
         // NOTE: the bitmap is a flop array, not RAM, so it can and must be reset to all-alive.
         alive_q     <= '1;
         pending_q   <= 1'b0;
         score       <= '0;
         dots_left   <= DOTS_FULL;
         eat_pulse   <= 1'b0;
         power_pulse <= 1'b0;
      end else if (level_restart) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         alive_q     <= '1;
         pending_q   <= 1'b0;
         dots_left   <= DOTS_FULL;
         eat_pulse   <= 1'b0;
         power_pulse <= 1'b0;
      end else begin
         eat_pulse   <= 1'b0;
         power_pulse <= 1'b0;
         if (eat_now) begin
            alive_q[cmp_idx] <= 1'b0;
            dots_left        <= dots_left - 1'b1;
            score            <= score_next;
            eat_pulse        <= 1'b1;
            power_pulse      <= rom.rom_power;
         end

         case (state_q)
            S_IDLE: begin
               if (frame_start || pending_q) begin
                  px_q       <= PacX;
                  py_q       <= PacY;
                  rom_addr_q <= '0;
                  cnt_q      <= '0;
                  pending_q  <= 1'b0;
                  state_q    <= S_SCAN;
               end
            end
            S_SCAN: begin
               pending_q <= pending_q | frame_start;
               cnt_q     <= cnt_q + 1'b1;
               if (rom_addr_q != LAST_ADDR)
                  rom_addr_q <= rom_addr_q + 1'b1;
               if (cnt_q == DOTS_FULL)
                  state_q <= S_DONE;
            end
            S_DONE: begin
               pending_q <= pending_q | frame_start;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_scan_controller.sv
// Self-checking bench for dot_scan_controller: directed and randomized scans
// against a dot-list model built from the hit/score rules.
module tb_dot_scan_controller;

   localparam int N = 64;

   logic        Clk = 1'b0;
   logic        Reset, frame_start, level_restart;
   logic [9:0]  PacX, PacY;
   logic [5:0]  qry_idx;
   logic        qry_alive;
   logic [15:0] score;
   logic [6:0]  dots_left;
   logic        eat_pulse, power_pulse, level_clear, scan_busy;

   dot_scan_controller_if #(.IDX_W(6)) rom_if ();

   dot_scan_controller dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_start   (frame_start),
      .level_restart (level_restart),
      .PacX          (PacX),
      .PacY          (PacY),
      .rom           (rom_if),
      .qry_idx       (qry_idx),
      .qry_alive     (qry_alive),
      .score         (score),
      .dots_left     (dots_left),
      .eat_pulse     (eat_pulse),
      .power_pulse   (power_pulse),
      .level_clear   (level_clear),
      .scan_busy     (scan_busy)
   );

   always #5 Clk = ~Clk;

   // Dot ROM with one cycle of read latency
   logic [9:0] rx_mem [N];
   logic [9:0] ry_mem [N];
   bit         rp_mem [N];

   always @(posedge Clk) begin
      rom_if.rom_x     <= rx_mem[rom_if.rom_addr];
      rom_if.rom_y     <= ry_mem[rom_if.rom_addr];
      rom_if.rom_power <= rp_mem[rom_if.rom_addr];
   end

   // Reference model state
   bit m_alive [N];
   int m_score;
   int m_dots;
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit model_hit(input int px, input int py, input int dx, input int dy);
      bit h = 0;
      foreach (m_alive[k]) begin end
      for (int sx = -8; sx <= 8; sx += 16)
         for (int sy = -8; sy <= 8; sy += 16)
            if (iabs(px + sx - dx) <= 4 && iabs(py + sy - dy) <= 4) h = 1;
      return h;
   endfunction

   function automatic void model_restore();
      for (int i = 0; i < N; i++) m_alive[i] = 1;
      m_dots = N;
   endfunction

   task automatic check_bitmap(input string tag);
      logic [63:0] got, exp;
      for (int i = 0; i < N; i++) begin
         qry_idx = 6'(i);
         #1;
         got[i] = qry_alive;
         exp[i] = m_alive[i];
      end
      check(tag, got, exp);
   endtask

   task automatic check_totals(input string tag);
      check({tag, "_score"}, 64'(score), 64'(m_score));
      check({tag, "_dots"},  64'(dots_left), 64'(m_dots));
      check({tag, "_clear"}, 64'(level_clear), 64'(m_dots == 0));
      check_bitmap({tag, "_bitmap"});
   endtask

   // One full frame scan: predict eaten dots in index order, then observe pulses
   task automatic run_scan(input int px, input int py, input string tag);
      int exp_idx[$];
      bit exp_pw[$];
      int got_idx[$];
      bit got_pw[$];
      int busy_n, orphan_pw, k;
      for (int i = 0; i < N; i++) begin
         if (m_alive[i] && model_hit(px, py, int'(rx_mem[i]), int'(ry_mem[i]))) begin
            exp_idx.push_back(i);
            exp_pw.push_back(rp_mem[i]);
            m_alive[i] = 0;
            m_dots--;
            m_score += rp_mem[i] ? 50 : 10;
            if (m_score > 65535) m_score = 65535;
         end
      end
      @(negedge Clk);
      PacX = 10'(px);
      PacY = 10'(py);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      busy_n = 0;
      orphan_pw = 0;
      k = 0;
      while (scan_busy === 1'b1 && k < 200) begin
         if (eat_pulse === 1'b1) begin
            got_idx.push_back(k - 2);
            got_pw.push_back(power_pulse);
         end else if (power_pulse !== 1'b0) begin
            orphan_pw++;
         end
         busy_n++;
         k++;
         @(negedge Clk);
      end
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd66);
      check({tag, "_eat_count"}, 64'(got_idx.size()), 64'(exp_idx.size()));
      if (got_idx.size() == exp_idx.size())
         for (int i = 0; i < exp_idx.size(); i++) begin
            check({tag, "_eat_idx"}, 64'(got_idx[i]), 64'(exp_idx[i]));
            check({tag, "_eat_power"}, 64'(got_pw[i]), 64'(exp_pw[i]));
         end
      check({tag, "_orphan_power"}, 64'(orphan_pw), 64'd0);
      check({tag, "_idle_no_pulse"}, 64'(eat_pulse), 64'd0);
      check_totals(tag);
   endtask

   task automatic restart_level();
      @(negedge Clk);
      level_restart = 1'b1;
      @(negedge Clk);
      level_restart = 1'b0;
      model_restore();
   endtask

   initial begin
      int busy_n, rises, clears;
      bit prev;
      Reset = 1'b1;
      frame_start = 1'b0;
      level_restart = 1'b0;
      PacX = '0;
      PacY = '0;
      qry_idx = '0;
      for (int i = 0; i < N; i++) begin
         rx_mem[i] = 10'(100 + (i % 8) * 100);
         ry_mem[i] = 10'(100 + (i / 8) * 100);
         rp_mem[i] = (i == 5);
      end
      model_restore();
      m_score = 0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      // Reset state
      check("rst_busy", 64'(scan_busy), 64'd0);
      check("rst_rom_addr", 64'(rom_if.rom_addr), 64'd0);
      check("rst_eat", 64'(eat_pulse), 64'd0);
      check("rst_power", 64'(power_pulse), 64'd0);
      check_totals("rst");

      // Far away, then dot 0 eaten once
      run_scan(600, 600, "far");
      run_scan(92, 92, "dot0");
      check("dot0_score_lit", 64'(score), 64'd10);
      check("dot0_dots_lit", 64'(dots_left), 64'd63);
      run_scan(92, 92, "dot0_again");

      // Window edges on dot 9 at (200,200): corner offset 5 misses, 4 hits
      run_scan(187, 192, "edge5");
      run_scan(188, 192, "edge4");
      check("edge4_score_lit", 64'(score), 64'd20);

      // Low-end corner must not wrap to 1018 and falsely hit a dot at x=1020
      rx_mem[1] = 10'd1020;
      ry_mem[1] = 10'd300;
      run_scan(2, 292, "wrap");

      // Power pellet at index 5
      run_scan(592, 92, "power");
      check("power_score_lit", 64'(score), 64'd70);

      // Two frame_starts mid-scan merge into exactly one extra scan
      @(negedge Clk);
      PacX = 10'd600;
      PacY = 10'd600;
      frame_start = 1'b1;
      busy_n = 0;
      rises = 0;
      prev = 0;
      for (int s = 0; s < 300; s++) begin
         @(negedge Clk);
         frame_start = (s == 10 || s == 20);
         if (scan_busy === 1'b1) busy_n++;
         if (scan_busy === 1'b1 && !prev) rises++;
         prev = (scan_busy === 1'b1);
      end
      check("pend_busy_total", 64'(busy_n), 64'd132);
      check("pend_scans", 64'(rises), 64'd2);
      check_totals("pend");

      // level_restart mid-scan with a pending request and a same-cycle frame_start
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      repeat (5) @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      repeat (4) @(negedge Clk);
      check("rsm_busy_before", 64'(scan_busy), 64'd1);
      level_restart = 1'b1;
      frame_start = 1'b1;
      @(negedge Clk);
      level_restart = 1'b0;
      frame_start = 1'b0;
      model_restore();
      check("rsm_idle_next", 64'(scan_busy), 64'd0);
      busy_n = 0;
      for (int s = 0; s < 80; s++) begin
         @(negedge Clk);
         if (scan_busy !== 1'b0) busy_n++;
      end
      check("rsm_stays_idle", 64'(busy_n), 64'd0);
      check_totals("rsm");
      check("rsm_score_lit", 64'(score), 64'd70);

      // Randomized dots clustered around Pac-Man positions
      for (int i = 0; i < N; i++) begin
         rx_mem[i] = 10'($urandom_range(50, 120));
         ry_mem[i] = 10'($urandom_range(50, 120));
         rp_mem[i] = ($urandom_range(0, 3) == 0);
      end
      for (int r = 0; r < 8; r++)
         run_scan(int'($urandom_range(45, 125)), int'($urandom_range(45, 125)), "rand");

      // All dots stacked and powered: clear the level repeatedly until score saturates
      for (int i = 0; i < N; i++) begin
         rx_mem[i] = 10'd300;
         ry_mem[i] = 10'd300;
         rp_mem[i] = 1;
      end
      clears = 0;
      restart_level();
      run_scan(292, 292, "clear");
      check("clear_flag_lit", 64'(level_clear), 64'd1);
      run_scan(292, 292, "after_clear");
      for (int lvl = 0; lvl < 30 && m_score < 65535; lvl++) begin
         restart_level();
         run_scan(292, 292, "sat");
         clears++;
      end
      restart_level();
      run_scan(292, 292, "sat_hold");
      check("sat_score_lit", 64'(score), 64'hFFFF);

      // Reset mid-scan aborts and restores everything
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
      repeat (10) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      model_restore();
      m_score = 0;
      check("rst2_busy", 64'(scan_busy), 64'd0);
      check("rst2_rom_addr", 64'(rom_if.rom_addr), 64'd0);
      check_totals("rst2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
